// File: rtl/regfile_rename_if.sv
// regfile_rename_if: decoder issue/lookup and ROB commit/flush signals for the renamed register file
interface regfile_rename_if #(
  parameter int REG_ID_BIT = 5,
  parameter int TAG_BIT = 4
);
  logic rdy_in;
  logic issue_en;
  logic [REG_ID_BIT-1:0] issue_rd;
  logic [TAG_BIT-1:0] issue_tag;
  logic [REG_ID_BIT-1:0] rs1_id;
  logic [REG_ID_BIT-1:0] rs2_id;
  logic rs1_busy;
  logic [TAG_BIT-1:0] rs1_tag;
  logic [31:0] rs1_value;
  logic rs2_busy;
  logic [TAG_BIT-1:0] rs2_tag;
  logic [31:0] rs2_value;
  logic commit_en;
  logic [REG_ID_BIT-1:0] commit_rd;
  logic [TAG_BIT-1:0] commit_tag;
  logic [31:0] commit_value;
  logic clear_all;
  modport master (
    output rdy_in, issue_en, issue_rd, issue_tag, rs1_id, rs2_id,
    output commit_en, commit_rd, commit_tag, commit_value, clear_all,
    input rs1_busy, rs1_tag, rs1_value, rs2_busy, rs2_tag, rs2_value
  );
  modport slave (
    input rdy_in, issue_en, issue_rd, issue_tag, rs1_id, rs2_id,
    input commit_en, commit_rd, commit_tag, commit_value, clear_all,
    output rs1_busy, rs1_tag, rs1_value, rs2_busy, rs2_tag, rs2_value
  );
endinterface

// File: rtl/regfile_rename.sv
// regfile_rename: architectural register file with busy bits and ROB producer tags.
// Define REGFILE_BYPASS_EN to forward a same-cycle commit onto the read ports.
module regfile_rename #(
  parameter int REG_NUM = 32,
  parameter int REG_ID_BIT = 5,
  parameter int TAG_BIT = 4
) (
  input logic clk_in,
  input logic rst_in,
  regfile_rename_if.slave bus
);
  logic [31:0] value [REG_NUM];
  logic [TAG_BIT-1:0] tag [REG_NUM];
  logic [REG_NUM-1:0] busy;
  // x0 is never written, so its entries stay at their reset value of zero
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      value <= '{default: '0};
      tag <= '{default: '0};
      busy <= '0;
    end else if (bus.rdy_in) begin
      for (int i = 1; i < REG_NUM; i++) begin
        if (bus.commit_en && bus.commit_rd == REG_ID_BIT'(i))
          value[i] <= bus.commit_value;
        if (bus.clear_all)
          busy[i] <= 1'b0;
        else if (bus.issue_en && bus.issue_rd == REG_ID_BIT'(i)) begin
          busy[i] <= 1'b1;
          tag[i] <= bus.issue_tag;
        end else if (bus.commit_en && bus.commit_rd == REG_ID_BIT'(i) && busy[i] && tag[i] == bus.commit_tag)
          busy[i] <= 1'b0;
      end
    end
  function automatic logic [TAG_BIT+32:0] lookup(input logic [REG_ID_BIT-1:0] id);
    logic b;
    logic [TAG_BIT-1:0] t;
    logic [31:0] v;
    b = busy[id];
    t = tag[id];
    v = value[id];
`ifdef REGFILE_BYPASS_EN
    // a stale-tag commit still writes the value but leaves the younger producer pending
    if (bus.rdy_in && bus.commit_en && bus.commit_rd == id && (!b || t == bus.commit_tag)) begin
      b = 1'b0;
      v = bus.commit_value;
    end
`endif
    return (id == '0) ? '0 : {b, t, v};
  endfunction
  always_comb {bus.rs1_busy, bus.rs1_tag, bus.rs1_value} = lookup(bus.rs1_id);
  always_comb {bus.rs2_busy, bus.rs2_tag, bus.rs2_value} = lookup(bus.rs2_id);
endmodule

// File: tb/tb_regfile_rename.sv
// tb_regfile_rename: directed vectors with hand-computed expectations for regfile_rename.
module tb_regfile_rename;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  regfile_rename_if bus ();
  regfile_rename dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));
  always #5 clk_in = ~clk_in;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask
  task automatic issue(input logic [4:0] rd, input logic [3:0] t);
    bus.issue_en = 1'b1;
    bus.issue_rd = rd;
    bus.issue_tag = t;
    step();
    bus.issue_en = 1'b0;
  endtask
  task automatic commit(input logic [4:0] rd, input logic [3:0] t, input logic [31:0] v);
    bus.commit_en = 1'b1;
    bus.commit_rd = rd;
    bus.commit_tag = t;
    bus.commit_value = v;
  endtask
  initial begin
    bus.rdy_in = 1'b1;
    bus.issue_en = 1'b0;
    bus.issue_rd = '0;
    bus.issue_tag = '0;
    bus.rs1_id = '0;
    bus.rs2_id = '0;
    bus.commit_en = 1'b0;
    bus.commit_rd = '0;
    bus.commit_tag = '0;
    bus.commit_value = '0;
    bus.clear_all = 1'b0;
    step();
    step();
    rst_in = 1'b0;
    step();
    bus.rs1_id = 5;
    #1;
    check("reset_busy", 32'(bus.rs1_busy), 0);
    check("reset_value", bus.rs1_value, 0);
    bus.issue_en = 1'b1;
    bus.issue_rd = 5;
    bus.issue_tag = 3;
    #1;
    check("issue_preread_busy", 32'(bus.rs1_busy), 0);
    step();
    bus.issue_en = 1'b0;
    check("x5_busy", 32'(bus.rs1_busy), 1);
    check("x5_tag", 32'(bus.rs1_tag), 3);
    commit(5, 3, 32'hDEADBEEF);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x5_byp_busy", 32'(bus.rs1_busy), 0);
    check("x5_byp_value", bus.rs1_value, 32'hDEADBEEF);
`else
    check("x5_same_busy", 32'(bus.rs1_busy), 1);
`endif
    step();
    bus.commit_en = 1'b0;
    check("x5_commit_busy", 32'(bus.rs1_busy), 0);
    check("x5_commit_value", bus.rs1_value, 32'hDEADBEEF);
    issue(7, 1);
    issue(7, 2);
    commit(7, 1, 10);
    step();
    bus.commit_en = 1'b0;
    bus.rs1_id = 7;
    #1;
    check("x7_stale_value", bus.rs1_value, 10);
    check("x7_stale_busy", 32'(bus.rs1_busy), 1);
    check("x7_stale_tag", 32'(bus.rs1_tag), 2);
    commit(7, 2, 20);
    step();
    bus.commit_en = 1'b0;
    check("x7_busy", 32'(bus.rs1_busy), 0);
    check("x7_value", bus.rs1_value, 20);
    commit(9, 4, 55);
    issue(9, 6);
    bus.commit_en = 1'b0;
    bus.rs2_id = 9;
    #1;
    check("x9_value", bus.rs2_value, 55);
    check("x9_busy", 32'(bus.rs2_busy), 1);
    check("x9_tag", 32'(bus.rs2_tag), 6);
    issue(0, 1);
    bus.rs1_id = 0;
    #1;
    check("x0_busy", 32'(bus.rs1_busy), 0);
    check("x0_tag", 32'(bus.rs1_tag), 0);
    check("x0_value", bus.rs1_value, 0);
    issue(3, 1);
    issue(4, 2);
    bus.rs1_id = 3;
    bus.rs2_id = 4;
    #1;
    check("x3_busy", 32'(bus.rs1_busy), 1);
    check("x4_busy", 32'(bus.rs2_busy), 1);
    bus.clear_all = 1'b1;
    issue(8, 5);
    bus.clear_all = 1'b0;
    check("clr_x3_busy", 32'(bus.rs1_busy), 0);
    check("clr_x4_busy", 32'(bus.rs2_busy), 0);
    bus.rs1_id = 8;
    bus.rs2_id = 5;
    #1;
    check("clr_x8_busy", 32'(bus.rs1_busy), 0);
    check("clr_x5_value", bus.rs2_value, 32'hDEADBEEF);
    issue(10, 7);
    bus.rdy_in = 1'b0;
    commit(10, 7, 123);
    bus.rs1_id = 10;
    step();
    check("stall_busy", 32'(bus.rs1_busy), 1);
    check("stall_value", bus.rs1_value, 0);
    bus.rdy_in = 1'b1;
    step();
    bus.commit_en = 1'b0;
    check("x10_busy", 32'(bus.rs1_busy), 0);
    check("x10_value", bus.rs1_value, 123);
    issue(6, 2);
    bus.rs2_id = 6;
    commit(6, 2, 99);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x6_byp_busy", 32'(bus.rs2_busy), 0);
    check("x6_byp_value", bus.rs2_value, 99);
`else
    check("x6_same_busy", 32'(bus.rs2_busy), 1);
`endif
    step();
    bus.commit_en = 1'b0;
    check("x6_busy", 32'(bus.rs2_busy), 0);
    check("x6_value", bus.rs2_value, 99);
    issue(5, 3);
    bus.rs1_id = 5;
    #1;
    check("pre_rst_busy", 32'(bus.rs1_busy), 1);
    rst_in = 1'b1;
    #1;
    check("async_rst_busy", 32'(bus.rs1_busy), 0);
    check("async_rst_tag", 32'(bus.rs1_tag), 0);
    check("async_rst_value", bus.rs1_value, 0);
    step();
    rst_in = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
